inst_align: RTL and testbench
=============================

Name: inst_align

Overview:
- Fetch-side aligner directly upstream of the 16-bit and 32-bit instruction decoders.
- Accepts 64-bit aligned fetch words from the fetch unit.
- Splits each word into RVC (16-bit) and full 32-bit instructions, including 32-bit instructions that straddle two fetch words.
- Presents one instruction per cycle with its PC and a compressed flag over a valid/ready handshake.

Parameters:
- XLEN, 64, PC width.
- FETCH_W, 64, fetch word width in bits; fixed at four halfwords.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- flush  in  1  redirect; discards all buffered state.
- redirect_pc  in  XLEN  new fetch PC, halfword aligned; sampled when flush=1.
- fetch_valid  in  1  fetch word valid.
- fetch_ready  out  1  aligner can accept a word this cycle.
- fetch_data  in  FETCH_W  fetch word; halfword 0 is bits [15:0].
- fetch_pc  in  XLEN  PC of fetch_data; bits [2:0]=0.
- inst_valid  out  1  instruction available.
- inst_ready  in  1  decode accepts the instruction.
- inst  out  32  instruction. For RVC: {16'b0, half}.
- inst_pc  out  XLEN  PC of inst.
- inst_rvc  out  1  inst[1:0] != 2'b11.

Behaviour:
- Internal state:
  - word_q: FETCH_W bits; wpc_q: XLEN bits.
  - off_q: 2 bits, halfword offset of the next instruction.
  - hold_q: 16 bits, low half of a straddling instruction; hpc_q: its PC.
  - st_q.
- FSM states:
  - EMPTY: no data.
  - WORD: word_q valid at off_q.
  - CROSS: hold_q valid, waiting for the next word.
  - CROSSW: hold_q valid and word_q valid.
- Reset, and flush (flush has priority over every other event in the same cycle):
  - st_q=EMPTY. inst_valid=0. fetch_ready=1 after reset.
  - off_q=0 on reset; off_q=redirect_pc[2:1] on flush. word_q, hold_q, wpc_q, hpc_q cleared to 0.
  - A fetch handshake in the flush cycle is dropped.
- First-word offset: the first word accepted after reset or flush uses the off_q already set, so halfwords below redirect_pc[2:1] are skipped.
- Latency: a word accepted in cycle N yields inst_valid in cycle N+1. Outputs are combinational from registers only.
- WORD, h = word_q half[off_q]:
  - If h[1:0]!=11: inst={16'b0,h}, inst_rvc=1, inst_pc=wpc_q+2*off_q, advance off_q by 1.
  - Else if off_q<3: inst={half[off_q+1],h}, inst_rvc=0, advance off_q by 2.
  - Else (off_q=3, 32-bit instruction): inst_valid=0; next cycle hold_q=h, hpc_q=wpc_q+6, st_q=CROSS. No instruction is emitted.
- Word end: when the advance reaches or passes offset 4 on a handshake, off_q wraps to advance-4 (always 0 here) and the word is consumed.
- CROSS: inst_valid=0 until a word arrives.
  - Accepting a word moves to CROSSW, with word_q and wpc_q loaded.
  - off_q=0 while in CROSS.
- CROSSW: inst={word_q half0, hold_q}, inst_pc=hpc_q, inst_rvc=0. On handshake: off_q=1, st_q=WORD.
- fetch_ready is asserted in any of these cases:
  - st_q=EMPTY or CROSS;
  - st_q=WORD, the current handshake consumes the last instruction of word_q, and no straddle is pending;
  - st_q=WORD with off_q=3 and h 32-bit (entering CROSS).
- The out-to-in combinational path (inst_ready to fetch_ready) is permitted. It gives full throughput on back-to-back words.
- A word accepted while the last instruction is consumed loads word_q directly, with off_q=0 and st_q=WORD. There is no bubble.
- inst_valid=0 and fetch_valid=0: state holds.
- inst_valid=1 and inst_ready=0: all outputs stay stable.
- PC arithmetic is modulo 2^XLEN; wrap at the top of the address space is not special-cased.

Optional Feature:
- Macro: INST_ALIGN_RVC_EN.
- Defined: behaviour as above.
- Undefined (no C extension):
  - Every instruction is 32-bit, taken at off_q in {0,2}, advance 2.
  - CROSS and CROSSW are removed; inst_rvc is tied to 0.
  - On flush, off_q={redirect_pc[2],1'b0}.
  - A halfword with [1:0]!=11 is still emitted as a 32-bit pair; decode flags it illegal.

Decomposition:
- Shared package fetch_pkg:
  - align_state_t enum {EMPTY, WORD, CROSS, CROSSW}.
  - hoff_t (2-bit halfword offset).
  - Constants HALF_W=16, HALVES=4.
  - Function is_rvc(half).
- One sub-module, inst_half_sel: combinational selection of half[off], half[off+1], the rvc flag, and the advance amount.

Test Plan:
- Straight-line RVC: word 0x0001_0001_0001_0001 @0x1000 -> 4 RVC insts, PCs 0x1000/2/4/6, one per cycle; fetch_ready high on the 4th handshake.
- Straight-line 32-bit: words 0x00000013_00000013 back-to-back @0x2000 and @0x2008 with inst_ready=1 -> PCs 0x2000, 0x2004, 0x2008, 0x200C on consecutive cycles, no bubbles.
- Straddle: word@0x3000 with halves {0x0001,0x0001,0x0001,0x0013}, then next word half0=0x0000 -> 3 RVC insts, then inst=0x0000_0013, pc=0x3006, rvc=0; next inst from pc 0x300A.
- Flush mid-word: flush with redirect_pc=0x4006, simultaneous fetch_valid -> that word dropped; next word@0x4000 yields first inst at pc 0x4006.
- Backpressure: inst_ready=0 for 5 cycles during a straddle -> inst/inst_pc stable, fetch_ready=0 in CROSSW, no word lost.
- Reset mid-CROSS: rst asserted -> inst_valid=0, fetch_ready=1 next cycle, off_q=0; with the macro undefined the first word gives 2 insts at off 0 and 2.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, constants and helpers for the fetch-side aligner.
package fetch_pkg;
  typedef enum logic [1:0] {EMPTY, WORD, CROSS, CROSSW} align_state_t;
  localparam int HALF_W = 16;
  localparam int HALVES = 4;
  typedef logic [$clog2(HALVES)-1:0] hoff_t;
  function automatic logic is_rvc(input logic [HALF_W-1:0] half);
    return half[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/inst_half_sel.sv
// inst_half_sel: picks half[off] and half[off+1] of a fetch word, classifies it and gives the offset advance.
// Compressed classification only exists when INST_ALIGN_RVC_EN is defined.
module inst_half_sel
  import fetch_pkg::*;
#(
  parameter int FETCH_W = 64
) (
  input  logic [FETCH_W-1:0] word_i,
  input  hoff_t              off_i,
  output logic [HALF_W-1:0]  h0_o,
  output logic [HALF_W-1:0]  h1_o,
  output logic               rvc_o,
  output logic [2:0]         adv_o
);
  hoff_t off_n;
  assign off_n = off_i + 2'd1;
  assign h0_o = word_i[{off_i, 4'b0} +: HALF_W];
  assign h1_o = word_i[{off_n, 4'b0} +: HALF_W];
`ifdef INST_ALIGN_RVC_EN
  assign rvc_o = is_rvc(h0_o);
`else
  assign rvc_o = 1'b0;
`endif
  assign adv_o = rvc_o ? 3'd1 : 3'd2;
endmodule

// File: rtl/inst_align.sv
// inst_align: splits 64-bit fetch words into one 16/32-bit instruction per cycle with PC and compressed flag.
// Define INST_ALIGN_RVC_EN for C-extension support (RVC and word-straddling 32-bit instructions).
module inst_align
  import fetch_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int FETCH_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [FETCH_W-1:0] fetch_data,
  input  logic [XLEN-1:0]    fetch_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst,
  output logic [XLEN-1:0]    inst_pc,
  output logic               inst_rvc
);
  align_state_t st_q, st_d;
  hoff_t off_q, off_d;
  logic [FETCH_W-1:0] word_q;
  logic [XLEN-1:0] wpc_q, hpc_q;
  logic [HALF_W-1:0] hold_q, h0, h1;
  logic [2:0] adv, sum;
  logic rvc, straddle, fetch_hs, unused_ok;
  inst_half_sel #(.FETCH_W(FETCH_W)) u_sel (
    .word_i(word_q),
    .off_i (off_q),
    .h0_o  (h0),
    .h1_o  (h1),
    .rvc_o (rvc),
    .adv_o (adv)
  );
  assign sum = {1'b0, off_q} + adv;
  assign fetch_hs = fetch_valid && fetch_ready;
  assign unused_ok = ^redirect_pc;
`ifdef INST_ALIGN_RVC_EN
  assign straddle = st_q == WORD && !rvc && off_q == 2'd3;
`else
  assign straddle = 1'b0;
  assign hold_q = '0;
  assign hpc_q = '0;
`endif
  always_comb begin
    inst_valid = (st_q == WORD && !straddle) || st_q == CROSSW;
    inst_rvc = st_q == WORD && rvc;
    inst = st_q == CROSSW ? {word_q[HALF_W-1:0], hold_q} : rvc ? {16'b0, h0} : {h1, h0};
    inst_pc = st_q == CROSSW ? hpc_q : wpc_q + {{(XLEN-3){1'b0}}, off_q, 1'b0};
    fetch_ready = st_q == EMPTY || st_q == CROSS || straddle || (st_q == WORD && inst_ready && sum[2]);
  end
  always_comb begin
    st_d = st_q;
    off_d = off_q;
    case (st_q)
      EMPTY: st_d = fetch_valid ? WORD : EMPTY;
      WORD: begin
        if (straddle) begin
          st_d = fetch_valid ? CROSSW : CROSS;
          off_d = '0;
        end else if (inst_ready) begin
          off_d = sum[1:0];
          st_d = !sum[2] ? WORD : fetch_valid ? WORD : EMPTY;
        end
      end
`ifdef INST_ALIGN_RVC_EN
      CROSS: st_d = fetch_valid ? CROSSW : CROSS;
      CROSSW: begin
        st_d = inst_ready ? WORD : CROSSW;
        off_d = inst_ready ? 2'd1 : off_q;
      end
`endif
      default: st_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      st_q <= EMPTY;
      word_q <= '0;
      wpc_q <= '0;
`ifdef INST_ALIGN_RVC_EN
      off_q <= rst ? 2'd0 : redirect_pc[2:1];
`else
      off_q <= rst ? 2'd0 : {redirect_pc[2], 1'b0};
`endif
    end else begin
      st_q <= st_d;
      off_q <= off_d;
      word_q <= fetch_hs ? fetch_data : word_q;
      wpc_q <= fetch_hs ? fetch_pc : wpc_q;
    end
  end
`ifdef INST_ALIGN_RVC_EN
  // the low half of a straddling instruction parks here until its upper half arrives
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hold_q <= '0;
      hpc_q <= '0;
    end else if (straddle) begin
      hold_q <= h0;
      hpc_q <= wpc_q + XLEN'(6);
    end
  end
`endif
endmodule

// File: tb/tb_inst_align.sv
// tb_inst_align: directed self-checking bench for inst_align (both INST_ALIGN_RVC_EN builds).
module tb_inst_align;
  logic clk, rst, flush, fetch_valid, fetch_ready, inst_valid, inst_ready, inst_rvc;
  logic [63:0] redirect_pc, fetch_data, fetch_pc, inst_pc;
  logic [31:0] inst;
  int n_chk = 0;
  int n_pass = 0;

  inst_align dut (
    .clk(clk), .rst(rst), .flush(flush), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data), .fetch_pc(fetch_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .inst_rvc(inst_rvc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic fv, input logic [63:0] fd, input logic [63:0] fp, input logic ir);
    fetch_valid = fv;
    fetch_data = fd;
    fetch_pc = fp;
    inst_ready = ir;
    #1;
  endtask

  task automatic exp_inst(input string tag, input logic [63:0] pc, input logic [31:0] ins,
                          input logic r, input logic fr);
    chk({tag, ".valid"}, inst_valid, 1);
    chk({tag, ".pc"}, inst_pc, pc);
    chk({tag, ".inst"}, inst, ins);
    chk({tag, ".rvc"}, inst_rvc, r);
    chk({tag, ".fready"}, fetch_ready, fr);
  endtask

  task automatic exp_idle(input string tag, input logic fr);
    chk({tag, ".valid"}, inst_valid, 0);
    chk({tag, ".fready"}, fetch_ready, fr);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    redirect_pc = '0;
    drv(0, 0, 0, 0);
    tick;
    tick;
    rst = 1'b0;
    exp_idle("reset", 1);

    // back-to-back 32-bit words, no bubble at the word boundary
    drv(1, 64'h00a00093_00000013, 64'h2000, 1);
    chk("b2b.accept", fetch_ready, 1);
    tick;
    drv(1, 64'h00100073_000000b3, 64'h2008, 1);
    exp_inst("b2b0", 64'h2000, 32'h00000013, 0, 0);
    tick;
    drv(1, 64'h00100073_000000b3, 64'h2008, 1);
    exp_inst("b2b1", 64'h2004, 32'h00a00093, 0, 1);
    tick;
    drv(0, 0, 0, 1);
    exp_inst("b2b2", 64'h2008, 32'h000000b3, 0, 0);
    tick;
    exp_inst("b2b3", 64'h200c, 32'h00100073, 0, 1);
    tick;
    exp_idle("b2b.end", 1);

    // decode backpressure keeps outputs stable
    drv(1, 64'h00300193_00200113, 64'h5000, 0);
    tick;
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0);
      exp_inst("bp.stall", 64'h5000, 32'h00200113, 0, 0);
      tick;
    end
    drv(0, 0, 0, 1);
    exp_inst("bp.go", 64'h5000, 32'h00200113, 0, 0);
    tick;
    exp_inst("bp1", 64'h5004, 32'h00300193, 0, 1);
    tick;
    exp_idle("bp.end", 1);

    // flush drops the simultaneous fetch and skips halves below the redirect
    drv(1, 64'h00300193_00200113, 64'h6000, 1);
    tick;
    flush = 1'b1;
    redirect_pc = 64'h4006;
    drv(1, 64'hffffffff_ffffffff, 64'h6008, 1);
    tick;
    flush = 1'b0;
    drv(0, 0, 0, 1);
    exp_idle("fl.drop", 1);
    drv(1, 64'h0001_0297_0000_0000, 64'h4000, 1);
    tick;
    drv(0, 0, 0, 1);
`ifdef INST_ALIGN_RVC_EN
    exp_inst("fl.first", 64'h4006, 32'h00000001, 1, 1);
`else
    exp_inst("fl.first", 64'h4004, 32'h00010297, 0, 1);
`endif
    tick;
    exp_idle("fl.end", 1);

    // reset after a flush to a nonzero offset restores offset 0
    flush = 1'b1;
    redirect_pc = 64'h8004;
    tick;
    flush = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drv(0, 0, 0, 1);
    exp_idle("rst.mid", 1);
    drv(1, 64'h0000006f_00000037, 64'h7000, 1);
    tick;
    drv(0, 0, 0, 1);
    exp_inst("rst.i0", 64'h7000, 32'h00000037, 0, 0);
    tick;
    exp_inst("rst.i1", 64'h7004, 32'h0000006f, 0, 1);
    tick;
    exp_idle("rst.end", 1);

`ifdef INST_ALIGN_RVC_EN
    // four compressed instructions from one word
    drv(1, 64'h0001_0001_0001_0001, 64'h1000, 1);
    tick;
    drv(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      exp_inst("rvc", 64'h1000 + 64'(2 * i), 32'h00000001, 1, i == 3);
      tick;
    end
    exp_idle("rvc.end", 1);

    // 32-bit instruction straddling two words, with backpressure in CROSSW
    drv(1, 64'h0013_0001_0001_0001, 64'h3000, 1);
    tick;
    drv(0, 0, 0, 1);
    exp_inst("sd0", 64'h3000, 32'h00000001, 1, 0);
    tick;
    exp_inst("sd1", 64'h3002, 32'h00000001, 1, 0);
    tick;
    exp_inst("sd2", 64'h3004, 32'h00000001, 1, 0);
    tick;
    exp_idle("sd.split", 1);
    tick;
    exp_idle("sd.cross", 1);
    drv(1, 64'h0000_0000_0001_0000, 64'h3008, 0);
    tick;
    for (int i = 0; i < 5; i++) begin
      drv(1, 64'hffffffff_ffffffff, 64'h3010, 0);
      exp_inst("sd.stall", 64'h3006, 32'h00000013, 0, 0);
      tick;
    end
    drv(0, 0, 0, 1);
    exp_inst("sd.join", 64'h3006, 32'h00000013, 0, 0);
    tick;
    exp_inst("sd.h1", 64'h300a, 32'h00000001, 1, 0);
    tick;
    exp_inst("sd.h2", 64'h300c, 32'h00000000, 1, 0);
    tick;
    exp_inst("sd.h3", 64'h300e, 32'h00000000, 1, 1);
    tick;
    exp_idle("sd.end", 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
